pb_multi_conditioner: RTL and testbench

//   Parametrised N-channel push-button conditioner: synchroniser, debounce, press/release
//   one-pulse and long-press detection per button, all on one clock domain.

---
 rtl/pb_pkg.sv | 23 ++
 rtl/pb_channel.sv | 146 ++++++++++++++
 rtl/pb_multi_conditioner.sv | 46 ++++
 tb/tb_pb_multi_conditioner.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pb_pkg.sv
// pb_pkg: shared types and defaults for the push-button conditioner.
// PB_REPEAT_EN (optional) enables auto-repeat press pulses while held.
package pb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRESSED,
        HELD
    } pb_state_t;

    localparam int PB_NUM_PB_DEF       = 4;
    localparam int PB_DEB_DEPTH_DEF    = 4;
    localparam int PB_HOLD_TICKS_DEF   = 100;
    localparam int PB_REPEAT_TICKS_DEF = 20;

    function automatic int pb_cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

    localparam int PB_HOLD_W_DEF   = pb_cnt_w(PB_HOLD_TICKS_DEF);
    localparam int PB_REPEAT_W_DEF = pb_cnt_w(PB_REPEAT_TICKS_DEF);

endpackage

// File: rtl/pb_channel.sv
// pb_channel: one button lane -- synchroniser, debounce, edge pulses, hold FSM.
// PB_REPEAT_EN adds auto-repeat press pulses in HELD.
module pb_channel
    import pb_pkg::*;
#(
    parameter int DEB_DEPTH  = PB_DEB_DEPTH_DEF,
    parameter int HOLD_TICKS = PB_HOLD_TICKS_DEF
`ifdef PB_REPEAT_EN
   ,parameter int REPEAT_TICKS = PB_REPEAT_TICKS_DEF
`endif
) (
    input  logic clk,
    input  logic reset,
    input  logic sample_tick,
    input  logic pb_in,
    output logic pb_deb,
    output logic pb_press,
    output logic pb_release,
    output logic pb_long
);

    localparam int HW = pb_cnt_w(HOLD_TICKS);

    logic [1:0]           sync_q;
    logic [DEB_DEPTH-1:0] sh_q;
    logic [DEB_DEPTH-1:0] sh_nxt;
    logic                 deb_q;
    logic                 deb_d;
    logic                 rise;
    logic                 fall;
    logic                 press_q;
    logic                 release_q;
    logic                 long_q;
    logic                 long_fire;
    logic                 rep_fire;
    pb_state_t            state_q;
    pb_state_t            state_n;
    logic [HW-1:0]        cnt_q;
    logic [HW-1:0]        cnt_n;
    logic [HW-1:0]        cnt_inc;
`ifdef PB_REPEAT_EN
    localparam int RW = pb_cnt_w(REPEAT_TICKS);
    logic [RW-1:0]        rep_q;
    logic [RW-1:0]        rep_n;
    logic [RW-1:0]        rep_inc;
    assign rep_inc = rep_q + RW'(1);
`endif

    assign sh_nxt  = {sh_q[DEB_DEPTH-2:0], sync_q[1]};
    assign rise    = deb_q & ~deb_d;
    assign fall    = ~deb_q & deb_d;
    assign cnt_inc = cnt_q + HW'(1);

    // Release is checked first so it always beats a coincident terminal count.
    always_comb begin
        state_n   = state_q;
        cnt_n     = cnt_q;
        long_fire = 1'b0;
        rep_fire  = 1'b0;
`ifdef PB_REPEAT_EN
        rep_n     = rep_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (rise) begin
                    state_n = PRESSED;
                    cnt_n   = '0;
                end
            end
            PRESSED: begin
                if (fall) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else if (sample_tick) begin
                    cnt_n = cnt_inc;
                    if (cnt_inc == HW'(HOLD_TICKS)) begin
                        long_fire = 1'b1;
                        state_n   = HELD;
                    end
                end
            end
            HELD: begin
                if (fall) begin
                    state_n = IDLE;
                    cnt_n   = '0;
`ifdef PB_REPEAT_EN
                    rep_n   = '0;
                end else if (sample_tick) begin
                    if (rep_inc == RW'(REPEAT_TICKS)) begin
                        rep_fire = 1'b1;
                        rep_n    = '0;
                    end else begin
                        rep_n = rep_inc;
                    end
`endif
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q    <= '0;
            sh_q      <= '0;
            deb_q     <= 1'b0;
            deb_d     <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
            state_q   <= IDLE;
            cnt_q     <= '0;
`ifdef PB_REPEAT_EN
            rep_q     <= '0;
`endif
        end else begin
            sync_q <= {sync_q[0], pb_in};
            if (sample_tick) begin
                sh_q <= sh_nxt;
                if (&sh_nxt) begin
                    deb_q <= 1'b1;
                end else if (~|sh_nxt) begin
                    deb_q <= 1'b0;
                end
            end
            deb_d     <= deb_q;
            press_q   <= rise | rep_fire;
            release_q <= fall;
            long_q    <= long_fire;
            state_q   <= state_n;
            cnt_q     <= cnt_n;
`ifdef PB_REPEAT_EN
            rep_q     <= rep_n;
`endif
        end
    end

    assign pb_deb     = deb_q;
    assign pb_press   = press_q;
    assign pb_release = release_q;
    assign pb_long    = long_q;

endmodule

// File: rtl/pb_multi_conditioner.sv
// pb_multi_conditioner: NUM_PB independent push-button conditioner lanes.
// Define PB_REPEAT_EN for auto-repeat press pulses while a button is held.
module pb_multi_conditioner
    import pb_pkg::*;
#(
    parameter int NUM_PB       = PB_NUM_PB_DEF,
    parameter int DEB_DEPTH    = PB_DEB_DEPTH_DEF,
    parameter int HOLD_TICKS   = PB_HOLD_TICKS_DEF,
    parameter int REPEAT_TICKS = PB_REPEAT_TICKS_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sample_tick,
    input  logic [NUM_PB-1:0] pb_in,
    output logic [NUM_PB-1:0] pb_deb,
    output logic [NUM_PB-1:0] pb_press,
    output logic [NUM_PB-1:0] pb_release,
    output logic [NUM_PB-1:0] pb_long
);

    generate
        if (DEB_DEPTH < 2 || HOLD_TICKS < 1 || REPEAT_TICKS < 1) begin : g_bad_param
            $error("pb_multi_conditioner: illegal DEB_DEPTH/HOLD_TICKS/REPEAT_TICKS");
        end
    endgenerate

    for (genvar i = 0; i < NUM_PB; i++) begin : g_ch
        pb_channel #(
            .DEB_DEPTH    (DEB_DEPTH),
            .HOLD_TICKS   (HOLD_TICKS)
`ifdef PB_REPEAT_EN
           ,.REPEAT_TICKS (REPEAT_TICKS)
`endif
        ) u_ch (
            .clk         (clk),
            .reset       (reset),
            .sample_tick (sample_tick),
            .pb_in       (pb_in[i]),
            .pb_deb      (pb_deb[i]),
            .pb_press    (pb_press[i]),
            .pb_release  (pb_release[i]),
            .pb_long     (pb_long[i])
        );
    end

endmodule

// File: tb/tb_pb_multi_conditioner.sv
// tb_pb_multi_conditioner: directed self-checking bench for the conditioner.
// Build with PB_REPEAT_EN defined to also exercise auto-repeat.
module tb_pb_multi_conditioner;

    logic       clk;
    logic       reset;
    logic       sample_tick;
    logic [3:0] pb_in;
    logic [3:0] pb_deb;
    logic [3:0] pb_press;
    logic [3:0] pb_release;
    logic [3:0] pb_long;

    int checks;
    int errors;

    pb_multi_conditioner #(
        .NUM_PB       (4),
        .DEB_DEPTH    (4),
        .HOLD_TICKS   (10),
        .REPEAT_TICKS (5)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .sample_tick (sample_tick),
        .pb_in       (pb_in),
        .pb_deb      (pb_deb),
        .pb_press    (pb_press),
        .pb_release  (pb_release),
        .pb_long     (pb_long)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic test_reset;
        reset = 1'b0;
        sample_tick = 1'b1;
        pb_in = '0;
        drain(3);
        checks++;
        if ({pb_deb, pb_press, pb_release, pb_long} !== 16'h0) begin
            errors++;
            $display("FAIL reset_outputs got %h want 0000",
                     {pb_deb, pb_press, pb_release, pb_long});
        end
        reset = 1'b1;
        drain(3);
        checks++;
        if ({pb_deb, pb_press, pb_release, pb_long} !== 16'h0) begin
            errors++;
            $display("FAIL post_reset_idle got %h want 0000",
                     {pb_deb, pb_press, pb_release, pb_long});
        end
    endtask

    // pb_in[0] rises before edge 1: deb at edge 6, press after edge 7 only
    task automatic test_clean_press;
        logic exp_deb, exp_press;
        int rel_n, long_n;
        pb_in[0] = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            #1;
            exp_deb   = (k >= 6);
            exp_press = (k == 7);
            checks++;
            if (pb_deb[0] !== exp_deb || pb_press[0] !== exp_press) begin
                errors++;
                $display("FAIL clean_press k=%0d deb=%b press=%b want deb=%b press=%b",
                         k, pb_deb[0], pb_press[0], exp_deb, exp_press);
            end
            checks++;
            if (pb_deb[3:1] !== 3'b0 || pb_press[3:1] !== 3'b0) begin
                errors++;
                $display("FAIL clean_press_others k=%0d deb=%b press=%b want 000",
                         k, pb_deb[3:1], pb_press[3:1]);
            end
        end
        @(negedge clk);
        pb_in[0] = 1'b0;
        rel_n = 0;
        long_n = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            rel_n += int'(pb_release[0]);
            long_n += int'(pb_long[0]);
        end
        checks++;
        if (rel_n !== 1 || long_n !== 0) begin
            errors++;
            $display("FAIL clean_release rel=%0d long=%0d want rel=1 long=0", rel_n, long_n);
        end
        @(negedge clk);
    endtask

    task automatic test_bounce;
        logic [3:0] pat;
        int press_n, rise_n, fall_n;
        logic prev;
        pat = 4'b0101;
        press_n = 0;
        rise_n = 0;
        fall_n = 0;
        prev = pb_deb[1];
        for (int k = 0; k < 24; k++) begin
            pb_in[1] = (k < 4) ? pat[k] : 1'b1;
            @(posedge clk);
            #1;
            press_n += int'(pb_press[1]);
            if (pb_deb[1] && !prev) rise_n++;
            if (!pb_deb[1] && prev) fall_n++;
            prev = pb_deb[1];
            @(negedge clk);
        end
        checks++;
        if (press_n !== 1) begin
            errors++;
            $display("FAIL bounce_press got %0d want 1", press_n);
        end
        checks++;
        if (rise_n !== 1 || fall_n !== 0) begin
            errors++;
            $display("FAIL bounce_deb_glitch rises=%0d falls=%0d want 1/0", rise_n, fall_n);
        end
        pb_in[1] = 1'b0;
        drain(12);
    endtask

    // press after edge 7, long after edge 17, release after edge 22
    task automatic test_hold;
        int press_n, long_n, rel_n, long_k, rel_k;
        press_n = 0; long_n = 0; rel_n = 0; long_k = -1; rel_k = -1;
        pb_in[2] = 1'b1;
        for (int k = 1; k <= 35; k++) begin
            @(posedge clk);
            #1;
            press_n += int'(pb_press[2]);
            if (pb_long[2]) begin long_n++; long_k = k; end
            if (pb_release[2]) begin rel_n++; rel_k = k; end
            @(negedge clk);
            if (k == 15) pb_in[2] = 1'b0;
        end
        checks++;
        if (long_n !== 1 || long_k !== 17) begin
            errors++;
            $display("FAIL hold_long n=%0d at=%0d want n=1 at=17", long_n, long_k);
        end
        checks++;
        if (rel_n !== 1 || rel_k !== 22) begin
            errors++;
            $display("FAIL hold_release n=%0d at=%0d want n=1 at=22", rel_n, rel_k);
        end
        checks++;
        if (press_n !== 1) begin
            errors++;
            $display("FAIL hold_press got %0d want 1", press_n);
        end
    endtask

    // debounced fall is acted on at edge 17, the same tick the count hits 10
    task automatic test_release_terminal;
        int long_n, rel_n, rel_k;
        long_n = 0; rel_n = 0; rel_k = -1;
        pb_in[3] = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk);
            #1;
            long_n += int'(pb_long[3]);
            if (pb_release[3]) begin rel_n++; rel_k = k; end
            checks++;
            if (pb_press[3] && pb_release[3]) begin
                errors++;
                $display("FAIL press_release_overlap k=%0d got 1 want 0", k);
            end
            @(negedge clk);
            if (k == 10) pb_in[3] = 1'b0;
        end
        checks++;
        if (long_n !== 0) begin
            errors++;
            $display("FAIL terminal_long got %0d want 0", long_n);
        end
        checks++;
        if (rel_n !== 1 || rel_k !== 17) begin
            errors++;
            $display("FAIL terminal_release n=%0d at=%0d want n=1 at=17", rel_n, rel_k);
        end
    endtask

    task automatic test_tick_gating;
        sample_tick = 1'b0;
        pb_in[3] = 1'b1;
        drain(20);
        checks++;
        if (pb_deb[3] !== 1'b0) begin
            errors++;
            $display("FAIL gated_deb got %b want 0", pb_deb[3]);
        end
        for (int t = 0; t < 3; t++) begin
            sample_tick = 1'b1;
            @(negedge clk);
            sample_tick = 1'b0;
            drain(2);
        end
        checks++;
        if (pb_deb[3] !== 1'b0) begin
            errors++;
            $display("FAIL three_ticks_deb got %b want 0", pb_deb[3]);
        end
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        checks++;
        if (pb_deb[3] !== 1'b1) begin
            errors++;
            $display("FAIL four_ticks_deb got %b want 1", pb_deb[3]);
        end
        sample_tick = 1'b1;
        pb_in[3] = 1'b0;
        drain(15);
    endtask

    task automatic test_reset_mid_hold;
        int pulse_n;
        pb_in[0] = 1'b1;
        drain(20);
        checks++;
        if (pb_deb[0] !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_deb got %b want 1", pb_deb[0]);
        end
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if ({pb_deb, pb_press, pb_release, pb_long} !== 16'h0) begin
            errors++;
            $display("FAIL async_reset got %h want 0000",
                     {pb_deb, pb_press, pb_release, pb_long});
        end
        pb_in[0] = 1'b0;
        drain(3);
        reset = 1'b1;
        pulse_n = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if ({pb_deb, pb_press, pb_release, pb_long} !== 16'h0) pulse_n++;
        end
        checks++;
        if (pulse_n !== 0) begin
            errors++;
            $display("FAIL post_reset_pulses got %0d want 0", pulse_n);
        end
        @(negedge clk);
    endtask

`ifdef PB_REPEAT_EN
    // long at 17; repeats every 5 ticks until the fall is seen at edge 43
    task automatic test_repeat;
        logic exp_press;
        int long_k, late_n;
        long_k = -1;
        late_n = 0;
        pb_in[1] = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk);
            #1;
            exp_press = (k == 7) || (k >= 22 && k <= 42 && (k - 22) % 5 == 0);
            checks++;
            if (pb_press[1] !== exp_press) begin
                errors++;
                $display("FAIL repeat_press k=%0d got %b want %b", k, pb_press[1], exp_press);
            end
            if (pb_long[1]) long_k = k;
            if (k > 43 && (pb_press[1] || pb_long[1])) late_n++;
            @(negedge clk);
            if (k == 36) pb_in[1] = 1'b0;
        end
        checks++;
        if (long_k !== 17) begin
            errors++;
            $display("FAIL repeat_long at=%0d want 17", long_k);
        end
        checks++;
        if (late_n !== 0) begin
            errors++;
            $display("FAIL repeat_after_release got %0d want 0", late_n);
        end
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b0;
        sample_tick = 1'b1;
        pb_in = '0;
        @(negedge clk);
        test_reset();
        test_clean_press();
        test_bounce();
        test_hold();
        test_release_terminal();
        test_tick_gating();
        test_reset_mid_hold();
`ifdef PB_REPEAT_EN
        test_repeat();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
